serial_adder: RTL and testbench

- Parametrised multi-cycle adder that adds two N-bit operands D bits per clock, carrying between digits in a register.
- Generalises the team's single-bit combinational full-adder cell into a width- and throughput-configurable sequential block with a start/done handshake.
- Intended as the area-lean adder for datapaths where latency is acceptable.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/digit_adder.sv | 25 ++
 rtl/serial_adder.sv | 148 ++++++++++++++
 tb/tb_serial_adder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N = 8;
    localparam int DEF_D = 1;

    function automatic int digit_count(input int n, input int d);
        return n / d;
    endfunction

    // One spare bit so the counter never wraps before reaching its terminal count.
    function automatic int cnt_width(input int n, input int d);
        return $clog2(n / d) + 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational D-bit ripple of full-adder cells; also exposes the carry into the top bit.
module digit_adder #(
    parameter int D = 1
) (
    input  logic [D-1:0] x,
    input  logic [D-1:0] y,
    input  logic         ci,
    output logic [D-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [D:0] w_c;

    assign w_c[0] = ci;

    for (genvar gi = 0; gi < D; gi++) begin : g_fa
        assign s[gi]     = x[gi] ^ y[gi] ^ w_c[gi];
        assign w_c[gi+1] = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
    end

    assign co    = w_c[D];
    assign c_msb = w_c[D-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle N-bit adder working D bits per clock with a start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' input (a - b via inverted B and forced carry-in).
module serial_adder
    import adder_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int D = DEF_D
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    localparam int NDIG = digit_count(N, D);
    localparam int CW   = cnt_width(N, D);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_acc;
    logic [N-1:0]   r_sum;
    logic           r_carry;
    logic           r_cout;
    logic           r_ovf;
    logic [CW-1:0]  r_cnt;

    logic [D-1:0]   w_s;
    logic           w_co;
    logic           w_cmsb;
    logic           w_last;
    logic [N-1:0]   w_acc_next;
    logic [N-1:0]   w_b_in;
    logic           w_c_in;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub | cin;
`else
    assign w_b_in = b;
    assign w_c_in = cin;
`endif

    digit_adder #(.D(D)) u_digit (
        .x     (r_a[D-1:0]),
        .y     (r_b[D-1:0]),
        .ci    (r_carry),
        .s     (w_s),
        .co    (w_co),
        .c_msb (w_cmsb)
    );

    // New digit enters at the top so the accumulator is aligned after the final digit.
    if (N == D) begin : g_single
        assign w_acc_next = w_s;
    end else begin : g_multi
        assign w_acc_next = {w_s, r_acc[N-1:D]};
    end

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_c_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> D;
                    r_b     <= r_b >> D;
                    r_acc   <= w_acc_next;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    // Result registers load on the edge entering DONE so they are valid during done.
                    if (w_last) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_co;
                        r_ovf  <= w_co ^ w_cmsb;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: two serial_adder instances (D=1 and D=4) against an arithmetic reference model.
module tb_serial_adder;

    localparam int ND0 = 8;
    localparam int ND1 = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif

    logic       rdy [2];
    logic       bsy [2];
    logic       dn  [2];
    logic [7:0] sm  [2];
    logic       co  [2];
    logic       ov  [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.N(8), .D(1)) u_dut_d1 (
        .clk(clk), .reset(reset), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .a(a), .b(b), .cin(cin),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
        .sum(sm[0]), .cout(co[0]), .overflow(ov[0])
    );

    serial_adder #(.N(8), .D(4)) u_dut_d4 (
        .clk(clk), .reset(reset), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .a(a), .b(b), .cin(cin),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
        .sum(sm[1]), .cout(co[1]), .overflow(ov[1])
    );

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Reference: plain 9-bit arithmetic; returns {overflow, cout, sum}.
    function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y,
                                           input logic ci, input logic sb);
        logic [7:0] ye;
        logic       ce;
        logic [8:0] t;
        logic       v;
        ye = sb ? ~y : y;
        ce = sb ? 1'b1 : ci;
        t  = {1'b0, x} + {1'b0, ye} + {8'd0, ce};
        v  = (x[7] == ye[7]) && (t[7] != x[7]);
        return {v, t[8], t[7:0]};
    endfunction

    function automatic logic sub_now();
`ifdef SERIAL_ADDER_SUB_EN
        return sub;
`else
        return 1'b0;
`endif
    endfunction

    // Transaction-level model: 0 = waiting, 1 = computing for N/D cycles, 2 = reporting.
    int         m_ph   [2];
    int         m_left [2];
    logic [9:0] m_pend [2];
    logic [9:0] m_res  [2];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_ph[i]   <= 0;
                m_left[i] <= 0;
                m_pend[i] <= '0;
                m_res[i]  <= '0;
            end else begin
                case (m_ph[i])
                    0: if (start) begin
                        m_pend[i] <= ref_add(a, b, cin, sub_now());
                        m_ph[i]   <= 1;
                        m_left[i] <= (i == 0) ? ND0 : ND1;
                    end
                    1: begin
                        m_left[i] <= m_left[i] - 1;
                        if (m_left[i] == 1) begin
                            m_ph[i]  <= 2;
                            m_res[i] <= m_pend[i];
                        end
                    end
                    default: m_ph[i] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check("ready", i, rdy[i], m_ph[i] == 0);
            check("busy",  i, bsy[i], m_ph[i] == 1);
            check("done",  i, dn[i],  m_ph[i] == 2);
            check("sum",   i, sm[i],  m_res[i][7:0]);
            check("cout",  i, co[i],  m_res[i][8]);
            check("ovf",   i, ov[i],  m_res[i][9]);
        end
    end

    task automatic set_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
        sub = s;
`else
        if (s) check("sub_unavailable", 0, 1, 0);
`endif
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!(rdy[0] && rdy[1]) && t < 40) begin
            @(posedge clk); #2;
            t++;
        end
        if (t >= 40) check("ready_timeout", 0, 0, 1);
    endtask

    // One addition with hand-computed expectations, plus done-cycle latency for both instances.
    task automatic op(input logic [7:0] xa, input logic [7:0] xb, input logic xc, input logic xs,
                      input logic [7:0] es, input logic ec, input logic ev);
        int j0, j1, n0;
        wait_ready();
        a = xa; b = xb; cin = xc; set_sub(xs);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        j0 = 0; j1 = 0; n0 = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (dn[0]) begin n0++; j0 = j; end
            if (dn[1]) j1 = j;
        end
        check("done_cycle_d1", 0, j0, 9);
        check("done_cycle_d4", 1, j1, 3);
        check("done_count",    0, n0, 1);
        for (int i = 0; i < 2; i++) begin
            check("lit_sum",  i, sm[i], es);
            check("lit_cout", i, co[i], ec);
            check("lit_ovf",  i, ov[i], ev);
        end
        $display("op a=%02h b=%02h cin=%0b sub=%0b -> sum=%02h cout=%0b ovf=%0b", xa, xb, xc, xs, sm[0], co[0], ov[0]);
        @(posedge clk); #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        set_sub(1'b0);
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", i, rdy[i], 1);
            check("rst_sum",   i, sm[i],  0);
        end
        reset = 1'b0;
        @(posedge clk); #2;

        op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
        op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        set_sub(1'b0);
`endif

        // start held high with operands changing: D=1 instance must use only the first set
        wait_ready();
        a = 8'hA7; b = 8'h6B; cin = 1'b1;
        start = 1'b1;
        n0 = 0;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk); #2;
            if (j == 9) start = 1'b0;
            else if (j < 9) begin a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); end
            @(negedge clk);
            if (dn[0]) n0++;
            if (j == 9) begin
                check("held_done", 0, dn[0], 1);
                check("held_sum",  0, sm[0], 8'h13);
                check("held_cout", 0, co[0], 1);
                check("held_ovf",  0, ov[0], 0);
            end
        end
        check("held_done_count", 0, n0, 1);
        $display("held-start run: sum=%02h dones=%0d", sm[0], n0);
        @(posedge clk); #2;

        // asynchronous reset in the fourth RUN cycle
        wait_ready();
        a = 8'h12; b = 8'h34; cin = 1'b0;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("arst_ready", i, rdy[i], 1);
            check("arst_busy",  i, bsy[i], 0);
            check("arst_done",  i, dn[i],  0);
            check("arst_sum",   i, sm[i],  0);
            check("arst_cout",  i, co[i],  0);
            check("arst_ovf",   i, ov[i],  0);
        end
        $display("async reset mid-run: ready=%0b sum=%02h", rdy[0], sm[0]);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk); #2;
        op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 3) == 0);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub = 1'($urandom);
`endif
            if (start && rdy[0])
                $display("rand start a=%02h b=%02h cin=%0b", a, b, cin);
        end
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
